// File: rtl/noc_pkg.sv
// Shared NoC flit definitions: widths, port destination codes and header extraction.
package noc_pkg;

    localparam int WD     = 40;
    localparam int DEST_W = 4;

    localparam logic [DEST_W-1:0] DEST_LOCAL = 4'b0010;
    localparam logic [DEST_W-1:0] DEST_X     = 4'b0100;
    localparam logic [DEST_W-1:0] DEST_Y     = 4'b1000;

    // The destination code travels in the top bits of every flit.
    function automatic logic [DEST_W-1:0] get_dest(input logic [WD-1:0] flit);
        return flit[WD-1 -: DEST_W];
    endfunction

endpackage

// File: rtl/noc_flit_sink_if.sv
// Router-to-sink write channel plus consumer read channel of one ejection port.
// wr_en is a fire-and-forget valid; full is advisory backpressure sampled late by
// the router, so a write while the FIFO holds DEPTH entries with no pop is dropped.
interface noc_flit_sink_if #(
    parameter int DEPTH = 8
) ();
    localparam int CW = $clog2(DEPTH) + 1;

    logic                   wr_en;
    logic [noc_pkg::WD-1:0] wdata;
    logic                   full;
    logic                   rd_en;
    logic [noc_pkg::WD-1:0] rdata;
    logic                   empty;
    logic [CW-1:0]          count;

    modport master (
        output wr_en, wdata, rd_en,
        input  full, rdata, empty, count
    );

    modport slave (
        input  wr_en, wdata, rd_en,
        output full, rdata, empty, count
    );
endinterface

// File: rtl/noc_sync_fifo.sv
// Show-ahead synchronous FIFO; occupancy is tracked by count, so the pointers wrap freely.
module noc_sync_fifo #(
    parameter int WD    = 40,
    parameter int DEPTH = 8,
    localparam int AW   = $clog2(DEPTH),
    localparam int CW   = AW + 1
) (
    input  logic          wclk,
    input  logic          rst_n,
    input  logic          wr_en,
    input  logic [WD-1:0] wdata,
    input  logic          rd_en,
    output logic [WD-1:0] rdata,
    output logic          empty,
    output logic [CW-1:0] count,
    output logic          wr_accept,
    output logic          wr_drop
);
    import noc_pkg::*;

    logic [WD-1:0] mem_q [DEPTH];
    logic [AW-1:0] wptr_q, wptr_d;
    logic [AW-1:0] rptr_q, rptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;

    // A pop in the same cycle frees the slot, so a write at full still lands.
    always_comb begin
        do_pop    = rd_en && (count_q != '0);
        wr_accept = wr_en && ((count_q != CW'(DEPTH)) || do_pop);
        wr_drop   = wr_en && !wr_accept;
    end

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (wr_accept) wptr_d = wptr_q + AW'(1);
        if (do_pop)    rptr_d = rptr_q + AW'(1);
        case ({wr_accept, do_pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage has no reset; a write presented during reset must not land.
    always_ff @(posedge wclk) begin
        if (rst_n && wr_accept) mem_q[wptr_q] <= wdata;
    end

    assign rdata = mem_q[rptr_q];
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/noc_flit_sink.sv
// Ejection endpoint: buffers router flits, drives skid backpressure, checks headers, keeps stats.
module noc_flit_sink #(
    parameter int                         WD      = noc_pkg::WD,
    parameter int                         DEST_W  = noc_pkg::DEST_W,
    parameter logic [noc_pkg::DEST_W-1:0] MY_DEST = noc_pkg::DEST_LOCAL,
    parameter int                         DEPTH   = 8,
    parameter int                         SKID    = 2,
    localparam int                        CW      = $clog2(DEPTH) + 1
) (
    input  logic                 wclk,
    input  logic                 rst_n,
    noc_flit_sink_if.slave       bus,
    input  logic                 clr,
    output logic [31:0]          rx_count,
    output logic [15:0]          misroute_count,
    output logic                 ovf
);
    import noc_pkg::*;

    logic        wr_accept, wr_drop, misrouted;
    logic [31:0] rx_count_q, rx_count_d;
    logic [15:0] misroute_count_q, misroute_count_d;
    logic        ovf_q, ovf_d;

    noc_sync_fifo #(.WD(WD), .DEPTH(DEPTH)) u_fifo (
        .wclk      (wclk),
        .rst_n     (rst_n),
        .wr_en     (bus.wr_en),
        .wdata     (bus.wdata),
        .rd_en     (bus.rd_en),
        .rdata     (bus.rdata),
        .empty     (bus.empty),
        .count     (bus.count),
        .wr_accept (wr_accept),
        .wr_drop   (wr_drop)
    );

    // Router sees full a cycle late, so SKID slots stay free for flits already in flight.
    assign bus.full = (bus.count >= CW'(DEPTH - SKID));

    assign misrouted = wr_accept && (get_dest(bus.wdata) != MY_DEST);

    always_comb begin
        rx_count_d       = rx_count_q;
        misroute_count_d = misroute_count_q;
        ovf_d            = ovf_q;
        if (clr) begin
            rx_count_d       = '0;
            misroute_count_d = '0;
            ovf_d            = 1'b0;
        end else begin
            if (wr_accept && (rx_count_q != '1))       rx_count_d       = rx_count_q + 32'd1;
            if (misrouted && (misroute_count_q != '1)) misroute_count_d = misroute_count_q + 16'd1;
            if (wr_drop)                               ovf_d            = 1'b1;
        end
    end

    always_ff @(posedge wclk) begin
        if (!rst_n) begin
            rx_count_q       <= '0;
            misroute_count_q <= '0;
            ovf_q            <= 1'b0;
        end else begin
            rx_count_q       <= rx_count_d;
            misroute_count_q <= misroute_count_d;
            ovf_q            <= ovf_d;
        end
    end

    assign rx_count       = rx_count_q;
    assign misroute_count = misroute_count_q;
    assign ovf            = ovf_q;

endmodule

// File: tb/tb_noc_flit_sink.sv
// Bench for noc_flit_sink: directed scenarios plus random traffic against a queue model.
module tb_noc_flit_sink;
    localparam int DEPTH = 8;
    localparam int SKID  = 2;
    localparam logic [3:0] MY = 4'b0010;

    logic        wclk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic [31:0] rx_count;
    logic [15:0] misroute_count;
    logic        ovf;

    int tests_run    = 0;
    int tests_failed = 0;

    logic [39:0]     exp_q[$];
    longint unsigned m_rx;
    int unsigned     m_mis;
    bit              m_ovf;

    noc_flit_sink_if #(.DEPTH(DEPTH)) bus ();

    noc_flit_sink #(.MY_DEST(MY), .DEPTH(DEPTH), .SKID(SKID)) dut (
        .wclk           (wclk),
        .rst_n          (rst_n),
        .bus            (bus.slave),
        .clr            (clr),
        .rx_count       (rx_count),
        .misroute_count (misroute_count),
        .ovf            (ovf)
    );

    always #5 wclk = ~wclk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, "_count"}, 64'(bus.count), 64'(exp_q.size()));
        check({tag, "_empty"}, 64'(bus.empty), 64'(exp_q.size() == 0));
        check({tag, "_full"},  64'(bus.full),  64'(exp_q.size() >= DEPTH - SKID));
        check({tag, "_rx"},    64'(rx_count),  64'(m_rx));
        check({tag, "_mis"},   64'(misroute_count), 64'(m_mis));
        check({tag, "_ovf"},   64'(ovf),       64'(m_ovf));
        if (exp_q.size() > 0) check({tag, "_rdata"}, 64'(bus.rdata), 64'(exp_q[0]));
    endtask

    // One clock: drive inputs, advance the model by the behavioural rules, compare everything.
    task automatic cycle(input string tag, input bit wr, input logic [39:0] data,
                         input bit rd, input bit cl);
        bit pop, acc, drop;
        bus.wr_en = wr;
        bus.wdata = data;
        bus.rd_en = rd;
        clr       = cl;
        pop  = rd && (exp_q.size() > 0);
        acc  = wr && ((exp_q.size() < DEPTH) || pop);
        drop = wr && !acc;
        @(posedge wclk);
        #1;
        if (pop) void'(exp_q.pop_front());
        if (acc) exp_q.push_back(data);
        if (cl) begin
            m_rx = 0; m_mis = 0; m_ovf = 0;
        end else begin
            if (acc && m_rx != 64'hFFFF_FFFF) m_rx++;
            if (acc && data[39:36] != MY && m_mis != 16'hFFFF) m_mis++;
            if (drop) m_ovf = 1;
        end
        check_all(tag);
        bus.wr_en = 1'b0;
        bus.rd_en = 1'b0;
        clr       = 1'b0;
    endtask

    task automatic do_reset(input bit wr);
        rst_n     = 1'b0;
        bus.wr_en = wr;
        bus.rd_en = 1'b0;
        bus.wdata = {4'h2, 36'(32'($urandom))};
        @(posedge wclk);
        #1;
        exp_q.delete();
        m_rx = 0; m_mis = 0; m_ovf = 0;
        rst_n     = 1'b1;
        bus.wr_en = 1'b0;
        check_all("reset");
    endtask

    function automatic logic [39:0] rand_flit();
        logic [3:0] hdr;
        case ($urandom_range(0, 3))
            0:       hdr = 4'b0010;
            1:       hdr = 4'b0100;
            2:       hdr = 4'b1000;
            default: hdr = 4'($urandom_range(0, 15));
        endcase
        return {hdr, 4'($urandom), 32'($urandom)};
    endfunction

    initial begin
        rst_n = 1'b0; clr = 1'b0;
        bus.wr_en = 1'b0; bus.rd_en = 1'b0; bus.wdata = '0;
        @(posedge wclk);
        do_reset(1'b0);

        // Three local flits, no reads.
        for (int i = 1; i <= 3; i++) cycle("w3", 1'b1, 40'h2_0000_0000 + 40'(i), 1'b0, 1'b0);
        check("t1_count", 64'(bus.count), 64'd3);
        check("t1_rdata", 64'(bus.rdata), 64'h2_0000_0001);
        check("t1_full",  64'(bus.full),  64'd0);

        // Fill towards full: full appears with count 6, writes 7 and 8 still land.
        for (int i = 4; i <= 8; i++) begin
            cycle("fill", 1'b1, 40'h2_0000_0000 + 40'(i), 1'b0, 1'b0);
            if (i == 5) check("full_at5", 64'(bus.full), 64'd0);
            if (i == 6) check("full_at6", 64'(bus.full), 64'd1);
        end
        cycle("drop9", 1'b1, 40'h2_0000_0009, 1'b0, 1'b0);
        check("drop_ovf",   64'(ovf),       64'd1);
        check("drop_count", 64'(bus.count), 64'd8);
        check("drop_rx",    64'(rx_count),  64'd8);

        // Clear stats, then simultaneous write+pop at full.
        cycle("clr", 1'b0, '0, 1'b0, 1'b1);
        cycle("wrrd_full", 1'b1, 40'h2_0000_000A, 1'b1, 1'b0);
        check("wrrd_count", 64'(bus.count), 64'd8);
        check("wrrd_ovf",   64'(ovf),       64'd0);
        check("wrrd_rdata", 64'(bus.rdata), 64'h2_0000_0002);

        // Misrouted flit still stored and read back intact.
        do_reset(1'b0);
        cycle("misroute", 1'b1, 40'h4_0000_0010, 1'b0, 1'b0);
        check("mis_count", 64'(misroute_count), 64'd1);
        check("mis_rdata", 64'(bus.rdata), 64'h4_0000_0010);
        cycle("mis_pop", 1'b0, '0, 1'b1, 1'b0);

        // 20 flits through a shallow window so both pointers wrap.
        for (int i = 0; i < 3; i++) cycle("wrap_pre", 1'b1, rand_flit(), 1'b0, 1'b0);
        for (int i = 0; i < 17; i++) cycle("wrap", 1'b1, rand_flit(), 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) cycle("wrap_drain", 1'b0, '0, 1'b1, 1'b0);
        check("wrap_empty", 64'(bus.empty), 64'd1);
        cycle("rd_empty", 1'b0, '0, 1'b1, 1'b0);

        // count=5 with ovf set: clr keeps data, reset with a write in flight stores nothing.
        for (int i = 0; i < 9; i++) cycle("ovf_fill", 1'b1, rand_flit(), 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) cycle("ovf_pop", 1'b0, '0, 1'b1, 1'b0);
        check("pre_clr_ovf", 64'(ovf), 64'd1);
        cycle("clr5", 1'b1, rand_flit(), 1'b0, 1'b1);
        check("clr5_rx",    64'(rx_count),  64'd0);
        check("clr5_count", 64'(bus.count), 64'd6);
        do_reset(1'b1);
        check("rst_count", 64'(bus.count), 64'd0);
        check("rst_empty", 64'(bus.empty), 64'd1);
        cycle("post_rst", 1'b1, 40'h2_0000_00AB, 1'b0, 1'b0);
        check("post_rst_rdata", 64'(bus.rdata), 64'h2_0000_00AB);

        // Random traffic.
        for (int i = 0; i < 400; i++)
            cycle("rand", $urandom_range(0, 99) < 60, rand_flit(),
                  $urandom_range(0, 99) < 50, $urandom_range(0, 99) < 3);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/noc_flit_sink.md
# noc_flit_sink

Ejection endpoint for one NoC router output port. It accepts 40-bit flits from the router's `data_to_*` / `wr_next_*_en` pair and buffers them in a small FIFO for the local consumer. It drives the router's `next_full_*` backpressure with skid margin, checks each flit's destination header against its own port code, and keeps receive, misroute and overflow statistics. One instance sits on each of the router outputs: local, x and y.

## Interface
- `WD`, 40: flit width.
- `DEST_W`, 4: header width; header is `wdata[WD-1:WD-DEST_W]`.
- `MY_DEST`, 4'b0010: expected header code for this port (local=0010, x=0100, y=1000).
- `DEPTH`, 8: FIFO entries; must be a power of 2 and ≥ 4.
- `SKID`, 2: entries reserved after `full` asserts; 1 ≤ SKID < DEPTH.

Ports:
- `wclk` input, 1 bit: clock; all logic is on the rising edge.
- `rst_n` input, 1 bit: reset, synchronous, active-low.
- `wr_en` input, 1 bit: flit valid from the router (`wr_next_*_en`).
- `wdata` input, WD bits: flit from the router (`data_to_*`).
- `full` output, 1 bit: backpressure to the router (`next_full_*`).
- `rd_en` input, 1 bit: consumer pop request.
- `rdata` output, WD bits: head flit, show-ahead.
- `empty` output, 1 bit: FIFO empty.
- `count` output, log2(DEPTH)+1 bits: current occupancy.
- `rx_count` output, 32 bits: flits accepted; saturates.
- `misroute_count` output, 16 bits: accepted flits whose header ≠ MY_DEST; saturates.
- `ovf` output, 1 bit: sticky; a flit was dropped.
- `clr` input, 1 bit: synchronous clear of `rx_count`, `misroute_count` and `ovf`.

## Operation
- Write acceptance: a flit is accepted when `wr_en` is high and either `count < DEPTH`, or `count == DEPTH` with a valid pop in the same cycle.
  - An accepted flit is stored at the write pointer.
  - The write pointer advances, wrapping modulo DEPTH.
- Drop: a write with `count == DEPTH` and no pop is dropped.
  - `ovf` sets to 1.
  - `rx_count` and `misroute_count` are unchanged.
  - FIFO contents are unchanged.
- Pop:
  - Valid pop: `rd_en && !empty`. The read pointer advances, wrapping modulo DEPTH.
  - `rd_en` while empty is ignored; no error.
- Occupancy: `count` goes +1 on accept only, −1 on pop only, and is unchanged on both or neither.
- Output flags:
  - `full = (count >= DEPTH-SKID)`, decoded combinationally from the `count` register.
  - `empty = (count == 0)`.
  - `rdata` is the memory word at the read pointer. It is undefined while empty; the bench must not check it then.
- Statistics:
  - Every accepted flit increments `rx_count`, saturating at 0xFFFF_FFFF.
  - An accepted flit whose header ≠ MY_DEST is still stored, and also increments `misroute_count`, saturating at 0xFFFF.
- `clr` behaviour:
  - `clr` zeroes the statistics and has priority over a same-cycle increment or `ovf` set.
  - `clr` does not touch FIFO contents or pointers.
- Reset: `rst_n=0` at an edge gives the following, regardless of in-flight writes or reads:
  - pointers = 0, `count` = 0;
  - `empty` = 1, `full` = 0;
  - `rx_count` = 0, `misroute_count` = 0, `ovf` = 0.
  - Memory contents are not reset.

## Timing
- Write latency: a flit accepted at edge N makes `empty` 0 and appears on `rdata` (if it is the head) after edge N, i.e. in cycle N+1.
- Pop visibility: after a pop at edge N, the next entry appears on `rdata` after edge N.
- `full` timing: `full` changes the cycle after the `count` change that crosses DEPTH-SKID. The router samples `full` one cycle late. SKID=2 therefore absorbs the flit in flight plus one more, so drops never occur with a compliant router.
- Counter timing: statistics update on the same edge as the accept, visible in cycle N+1.
- Wrap-around: the pointer is log2(DEPTH) bits with natural wrap. Full versus empty is disambiguated by `count`, never by pointer equality.

## Structure
- Package `noc_pkg` holds:
  - `WD`, `DEST_W`;
  - the destination codes `DEST_X`=4'b0100, `DEST_Y`=4'b1000, `DEST_LOCAL`=4'b0010;
  - a function extracting the header from a flit.
- Sub-module `noc_sync_fifo` is parameterised by WD and DEPTH and contains:
  - the memory and pointers, with the count logic;
  - the simultaneous read/write at full case.
- Top level `noc_flit_sink` contains the full/skid decode, the header check, the statistics counters and `ovf`.

## Test plan
- Reset, then write 3 flits 0x2_0000_0001..3 with `rd_en`=0 → `count`=3, `rx_count`=3, `misroute_count`=0, `rdata`=0x2_0000_0001, `full`=0.
- With DEPTH=8, SKID=2, write continuously with no reads:
  - `full` rises the cycle after `count` reaches 6;
  - writes 7 and 8 are accepted;
  - a 9th write with `full` ignored → `ovf`=1, `count`=8, `rx_count`=8.
- At `count`=8, assert `wr_en` and `rd_en` together → `count` stays 8, `ovf` stays 0, and `rdata` advances to the second flit.
- Write 0x4_0000_0010 to a MY_DEST=0010 instance → `misroute_count`=1, flit stored, and read back unchanged.
- Perform 20 write/read pairs with `count` kept between 0 and 3 → the output order equals the input order across pointer wrap, and `empty`=1 at the end.
- At `count`=5 with `ovf`=1:
  - pulse `clr` → statistics are 0 and `count`=5;
  - assert `rst_n`=0 for one edge while `wr_en`=1 → `count`=0, `empty`=1, and the flit is not stored.
